// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  // Operation select as presented on the op input.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // One iteration per result bit.
  localparam int ITERS = 32;

  // Quotient reported for any divide by zero.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negate: out_o = neg_i ? -in_i : in_i.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: in_i (W-bit value), neg_i (negate select), out_o (W-bit result).
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + {{(W-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: 32-iteration shift-add multiply and restoring divide.
// Latency: start sampled on E0, hi/lo updated on E33, done pulses in the cycle after E33.
// Backpressure: busy is high for 33 cycles; start and mthi/mtlo are ignored while busy.
// Ports: clk/reset (async active-high); start/op/a/b launch an operation;
//        we_hi/we_lo/wd implement mthi/mtlo; busy/done/hi/lo are all registered.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] CNT_INIT = 5'(ITERS - 1);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               div_q, div_d;          // 1 = divide, 0 = multiply
  logic               neg_quo_q, neg_quo_d;  // negate product / quotient in FIX
  logic               neg_rem_q, neg_rem_d;  // negate remainder in FIX
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opb_q, opb_d;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;          // {hi_part, multiplier} or {rem, quo}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes at accept; op[0] clear means a signed operation.
  logic               sgn_in;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign sgn_in = ~op[0];

  cond_negate #(.W(WIDTH)) u_abs_a (.in_i(a), .neg_i(sgn_in & a[WIDTH-1]), .out_o(a_mag));
  cond_negate #(.W(WIDTH)) u_abs_b (.in_i(b), .neg_i(sgn_in & b[WIDTH-1]), .out_o(b_mag));

  // Sign fixup of the finished results.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  cond_negate #(.W(2*WIDTH)) u_fix_prod (.in_i(acc_q), .neg_i(neg_quo_q), .out_o(prod_fix));
  cond_negate #(.W(WIDTH)) u_fix_quo (.in_i(acc_q[WIDTH-1:0]), .neg_i(neg_quo_q), .out_o(quo_fix));
  cond_negate #(.W(WIDTH)) u_fix_rem (.in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .out_o(rem_fix));

  // Shared add/subtract path. For divide the left-shifted remainder needs 33
  // bits, so x carries one extra bit; bit 33 of the result is the borrow and
  // bit 32 is the multiply carry.
  logic [WIDTH:0]   add_x, add_y;
  logic             add_sub;
  logic [WIDTH+1:0] add_res;

  always_comb begin
    add_y = {1'b0, opb_q};
    if (div_q) begin
      add_x   = acc_q[2*WIDTH-1:WIDTH-1];
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_sub = 1'b0;
    end
    add_res = {1'b0, add_x} + ({1'b0, add_y} ^ {(WIDTH+2){add_sub}})
            + {{(WIDTH+1){1'b0}}, add_sub};
  end

  // One iteration of the accumulator.
  logic [2*WIDTH-1:0] step_acc;

  always_comb begin
    if (div_q) begin
      if (!add_res[WIDTH+1]) begin
        step_acc = {add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        step_acc = {add_res[WIDTH:0], acc_q[WIDTH-1:1]};
      end else begin
        step_acc = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CALC;
          cnt_d     = CNT_INIT;
          busy_d    = 1'b1;
          div_d     = op[1];
          neg_quo_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = sgn_in & a[WIDTH-1];
          div0_d    = op[1] & (b == '0);
          if (op[1]) begin
            opb_d = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opb_d = a_mag;
            acc_d = {{WIDTH{1'b0}}, b_mag};
          end
        end else begin
          // start takes priority; mthi/mtlo only land when nothing launches.
          if (we_hi) hi_d = wd;
          if (we_lo) lo_d = wd;
        end
      end

      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = ST_FIX;
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (div_q) begin
          // With a zero divisor every trial subtract succeeds, leaving
          // rem = |a|; the sign fixup restores a, so only lo needs forcing.
          lo_d = div0_q ? DIV0_LO : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        we_hi, we_lo;
  logic [31:0] wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, {hi, lo}.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx, sy;
    logic [63:0] r;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        r = p;
      end
      2'b01: r = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 0)                                      r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else                                             r = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Cycle-level reference: an operation accepted in idle completes 33 edges later.
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  int          m_cnt;
  logic [63:0] m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0; m_res = 64'd0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_cnt  = 33;
          m_res  = ref_res(op, a, b);
        end else begin
          if (we_hi) m_hi = wd;
          if (we_lo) m_lo = wd;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_hi, m_lo} = m_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // Called at #1 after an edge. Launches an op; inj>0 pulses start/mthi/mtlo
  // that many cycles into the busy window. Returns #1 after the done edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inj, input bit lit, input logic [31:0] ehi, input logic [31:0] elo,
                       input string tag);
    int n;
    bit seen;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      if (inj > 0 && n == inj) begin
        start = 1'b1;
        if (lit) begin
          op = 2'b01; a = 32'd2; b = 32'd2; we_hi = 1'b1; we_lo = 1'b0; wd = 32'h0000_DEAD;
        end else begin
          op = 2'($urandom); a = $urandom; b = $urandom;
          we_hi = 1'($urandom); we_lo = 1'($urandom); wd = $urandom;
        end
      end
      @(posedge clk); #1;
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, n);
    end else if (lit) begin
      chk({tag, " latency"}, 32'(n), 32'd33);
      chk({tag, " hi"}, hi, ehi);
      chk({tag, " lo"}, lo, elo);
    end
  endtask

  task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
    we_hi = wh; we_lo = wl; wd = d;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 15));
      4:       v = 32'(-32'($urandom_range(1, 15)));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    we_hi = 1'b0; we_lo = 1'b0; wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7,         0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2,         0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    do_op(2'b11, 32'h1234_5678, 32'd0,         0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, "divu by0");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0,         0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div by0 neg");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000, 32'h8000_0000, "div ovf");

    // mthi/mtlo, separately and together.
    mt(1'b1, 1'b0, 32'h1111_2222);
    chk("mthi hi", hi, 32'h1111_2222);
    mt(1'b0, 1'b1, 32'h3333_4444);
    chk("mtlo lo", lo, 32'h3333_4444);
    chk("mtlo hi kept", hi, 32'h1111_2222);
    mt(1'b1, 1'b1, 32'h5555_6666);
    chk("mthilo hi", hi, 32'h5555_6666);
    chk("mthilo lo", lo, 32'h5555_6666);

    // Start together with a write: start wins.
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'hBAD0_BAD0;
    do_op(2'b01, 32'd6, 32'd7, 0, 1'b1, 32'd0, 32'd42, "start+mt");

    // Start and mthi during busy are both ignored, only one done.
    do_op(2'b01, 32'd3, 32'd5, 10, 1'b1, 32'd0, 32'd15, "busy ignore");
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("busy ignore extra done", 32'(pulses), 32'd0);

    // Reset mid-divide.
    op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    mt(1'b0, 1'b1, 32'hA5A5_A5A5);
    chk("post reset mtlo", lo, 32'hA5A5_A5A5);
    do_op(2'b01, 32'd0, 32'd9, 0, 1'b1, 32'd0, 32'd0, "multu 0*9");

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: mt(1'($urandom), 1'($urandom), $urandom);
        1: do_op(2'($urandom), rnd_opnd(), rnd_opnd(), $urandom_range(1, 32), 1'b0, 32'd0, 32'd0, "rand inj");
        2: repeat ($urandom_range(1, 3)) @(posedge clk);
        default: do_op(2'($urandom), rnd_opnd(), rnd_opnd(), 0, 1'b0, 32'd0, 32'd0, "rand op");
      endcase
      #0;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage. It sits beside the ALU, takes the same two register-file read operands, and holds the architectural HI/LO registers that mfhi/mflo read and mthi/mtlo write. It executes mult, multu, div and divu in a fixed 33-cycle sequence using one shared 32-bit add/subtract path. It exposes a busy/done handshake so the controller can stall dependent mfhi/mflo instructions.

## Interface
- WIDTH, 32: operand and HI/LO width. Only 32 is supported.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  launch the operation in `op`. Sampled only in IDLE.
- op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- we_hi  in  1  mthi write strobe.
- we_lo  in  1  mtlo write strobe.
- wd  in  WIDTH  mthi/mtlo write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE → CALC on start.
  - CALC → FIX after 32 iterations; a 5-bit counter runs 31 down to 0.
  - FIX → IDLE.
- On accept:
  - Latch op.
  - Latch |a| and |b| for signed ops; raw a and b for unsigned ops.
  - Latch neg_q = a[31]^b[31] and neg_r = a[31]. Both are 0 for unsigned ops.
- Multiply, radix-2 shift-add on a 64-bit accumulator:
  - Each CALC cycle, if the multiplier LSB is 1, add the multiplicand to the upper half, capturing the carry.
  - Then shift right by 1.
  - In FIX, negate the 64-bit product if neg_q. Then hi = product[63:32] and lo = product[31:0].
- Divide, restoring:
  - Each CALC cycle, shift {rem, quo} left by 1 and trial-subtract the divisor.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1.
  - In FIX:
    - lo = quotient, negated if neg_q.
    - hi = remainder, negated if neg_r. The remainder takes the sign of the dividend.
- Divide by zero is detected at accept and still runs the full sequence. Result: lo = 0xFFFFFFFF, hi = a unmodified, in both signed and unsigned modes.
- 0x80000000 / 0xFFFFFFFF (div): lo = 0x80000000, hi = 0. No trap.
- mthi/mtlo:
  - Applied only in IDLE, at the clock edge.
  - we_hi and we_lo may be asserted together; both registers take wd.
  - Writes while busy are discarded.
- Start while busy is ignored. The in-flight operation is unaffected.
- Start together with we_hi/we_lo in IDLE: start wins, and the write is discarded.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - hi = 0, lo = 0, busy = 0, done = 0.
  - All internal accumulators 0.
- Let E0 be the edge that samples start in IDLE.
  - busy is high from after E0 through the edge E33, i.e. 33 cycles.
  - CALC iterations occur on edges E1 through E32.
  - FIX writes hi/lo on E33.
- done is registered. It is high for exactly the cycle after E33, coincident with the new hi/lo values and busy = 0.
- A new start may be sampled on E34 (the done cycle). Back-to-back throughput is one operation per 34 cycles.
- hi/lo hold their value throughout CALC and FIX. No partial results are visible.
- An mthi/mtlo write in IDLE is visible on hi/lo the cycle after the edge.
- Reset asserted mid-operation:
  - Immediately returns to IDLE with hi = lo = 0 and busy = done = 0.
  - The aborted operation has no effect.
  - Operation resumes normally on the first edge after deassertion.
- All outputs are driven directly from flops. There is no combinational path from any input to any output.

## Structure
- Package muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings: ST_IDLE, ST_CALC, ST_FIX.
  - Constant ITERS = 32.
  - DIV0_LO = 32'hFFFF_FFFF.
- Sub-module cond_negate:
  - Parameterised width; out = neg ? ~in + 1 : in.
  - Instantiated at 32 bits for operand absolute values and the quotient/remainder fixup.
  - Instantiated at 64 bits for the product fixup.
- The FSM, counter, shared add/subtract step and HI/LO registers stay in muldiv_unit.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → done 34 cycles after the start cycle; hi=0xFFFFFFFE, lo=0x00000001.
- mult a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21).
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- Divide-by-zero and overflow cases:
  - divu a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678.
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start and mthi ignored while busy: pulse start (op=multu, a=b=2) and mthi wd=0xDEAD at cycle 10 of an in-flight multu 3×5 → only hi=0, lo=15 results; a single done pulse.
- Reset at cycle 20 of a div → busy=0, hi=lo=0 immediately. A following mtlo wd=0xA5A5A5A5 then multu 0×9 → lo=0 at done.
